// File: rtl/neopixel_rx_fsm_pkg.sv
// Shared NeoPixel line timing (20.46 MHz OSCH), receiver state encoding and helpers.
package neopixel_rx_fsm_pkg;

  // Line timing in clk cycles (~48.9 ns each), shared with the transmitter
  localparam int T0H    = 7;     // ~0.35 us high for a '0'
  localparam int T1H    = 14;    // ~0.70 us high for a '1'
  localparam int TBIT   = 26;    // ~1.25 us full bit period
  localparam int TRESET = 1024;  // ~50 us latch gap

  // Receiver states
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // err_code values
  localparam logic [1:0] ERR_GLITCH  = 2'd1;
  localparam logic [1:0] ERR_STUCK   = 2'd2;
  localparam logic [1:0] ERR_PARTIAL = 2'd3;

  // Saturating 8-bit increment for pixel counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/neopixel_rx_fsm_sync.sv
// Brings the asynchronous serial line into clk and produces registered edge strobes.
// line, rise and fall are aligned: rise/fall are high in the first cycle line shows its new level.
module neopixel_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic line,
  output logic rise,
  output logic fall
);

  logic s1, s2;

  // 2-FF synchroniser, third stage holds the level the FSM works with
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      line <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      line <= s2;
      rise <= s2 & ~line;
      fall <= ~s2 & line;
    end
  end

endmodule

// File: rtl/neopixel_rx_fsm.sv
// WS2812 single-wire receiver: measures high widths of the synchronised line, decodes bits,
// assembles 24-bit {G,R,B} pixels and reports frame ends (latch gap) and line errors.
module neopixel_rx_fsm
  import neopixel_rx_fsm_pkg::*;
#(
  parameter int BIT_THRESH   = 12,
  parameter int MIN_HIGH     = 3,
  parameter int HIGH_MAX     = 40,
  parameter int RESET_CYCLES = TRESET,
  parameter int CNT_W        = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic [7:0]  pix_index,
  output logic        frame_done,
  output logic [7:0]  frame_pixels,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [CNT_W-1:0] THR_1   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] THR_MIN = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] LIM_HI  = CNT_W'(HIGH_MAX - 1);
  localparam logic [CNT_W-1:0] LIM_GAP = CNT_W'(RESET_CYCLES - 1);

  logic             line, rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;     // sync-low, high-time or low-time depending on state
  logic [4:0]       bitcnt;
  logic [23:0]      shreg;
  logic [7:0]       pixcnt;
  logic             bit_val;

  neopixel_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .line (line),
    .rise (rise),
    .fall (fall)
  );

  assign bit_val = (cnt >= THR_1);
  assign busy    = (state == ST_HIGH) || (state == ST_LOW);

  // Receiver FSM, pulse timing and pixel assembly; strobes default low every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      pixcnt       <= '0;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      pix_index    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_SYNC: begin
          // Need an unbroken latch gap before trusting bit alignment
          if (line) begin
            cnt <= '0;
          end else if (cnt >= LIM_GAP) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          bitcnt <= '0;
          pixcnt <= '0;
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (cnt < THR_MIN) begin
              err      <= 1'b1;
              err_code <= ERR_GLITCH;
              state    <= ST_SYNC;
              cnt      <= CNT_W'(1);  // the falling-edge cycle is already low
            end else begin
              shreg <= {shreg[22:0], bit_val};
              state <= ST_LOW;
              cnt   <= CNT_W'(1);
              if (bitcnt == 5'd23) begin
                pix_data  <= {shreg[22:0], bit_val};
                pix_valid <= 1'b1;
                pix_index <= pixcnt;
                pixcnt    <= sat_inc8(pixcnt);
                bitcnt    <= '0;
              end else begin
                bitcnt <= bitcnt + 5'd1;
              end
            end
          end else if (cnt >= LIM_HI) begin
            err      <= 1'b1;
            err_code <= ERR_STUCK;
            state    <= ST_SYNC;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // ST_LOW
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_W'(1);
          end else if (cnt >= LIM_GAP) begin
            frame_done   <= 1'b1;
            frame_pixels <= pixcnt;
            if (bitcnt != 5'd0) begin
              err      <= 1'b1;
              err_code <= ERR_PARTIAL;
            end
            bitcnt <= '0;
            state  <= ST_IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_rx_fsm.sv
// Bench for neopixel_rx_fsm: pulse-level reference model + event scoreboard,
// a vector table of decode cases, hand sequences for corner cases and random frames.
module tb_neopixel_rx_fsm;
  import neopixel_rx_fsm_pkg::*;

  localparam int M_THRESH = 12;
  localparam int M_MINH   = 3;
  localparam int M_HMAX   = 40;
  localparam int M_GAP    = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic [7:0]  pix_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  neopixel_rx_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // kind 0 = pixel (a=data, b=index), 1 = frame (a=pixels), 2 = error (a=code)
  typedef struct {
    int          kind;
    logic [23:0] a;
    logic [7:0]  b;
  } ev_t;

  typedef struct {
    logic [23:0] word;
    int          t0;
    int          t1;
    int          tl;
    logic [23:0] exp_data;
  } vec_t;

  ev_t exp_q[$];
  ev_t act_q[$];
  int  exp_rd = 0;
  int  act_rd = 0;
  int  n_coinc = 0;
  int  nchk = 0;
  int  nfail = 0;

  // Reference model state (pulse level)
  bit          m_sync;
  bit          m_inframe;
  int          m_bits;
  int          m_pix;
  int          m_run;
  logic [23:0] m_sh;

  // Capture every strobe the DUT raises
  always @(negedge clk) begin
    if (rst) begin
      if (pix_valid)  act_q.push_back('{kind: 0, a: pix_data, b: pix_index});
      if (frame_done) act_q.push_back('{kind: 1, a: {16'd0, frame_pixels}, b: 8'd0});
      if (err)        act_q.push_back('{kind: 2, a: {22'd0, err_code}, b: 8'd0});
      if (pix_valid && frame_done) n_coinc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_sync = 0; m_inframe = 0; m_bits = 0; m_pix = 0; m_run = 0; m_sh = '0;
  endtask

  task automatic m_push(input int k, input logic [23:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // A high pulse of w cycles
  task automatic m_high(input int w);
    if (m_sync) begin
      if (w >= M_HMAX || w < M_MINH) begin
        m_push(2, (w >= M_HMAX) ? 24'd2 : 24'd1, 8'd0);
        m_sync = 0; m_inframe = 0; m_bits = 0; m_pix = 0;
      end else begin
        m_inframe = 1;
        m_sh = {m_sh[22:0], (w >= M_THRESH) ? 1'b1 : 1'b0};
        m_bits++;
        if (m_bits == 24) begin
          m_push(0, m_sh, 8'(m_pix));
          m_pix = (m_pix < 255) ? m_pix + 1 : 255;
          m_bits = 0;
        end
      end
    end
    m_run = 0;
  endtask

  // L more low cycles; crossing the gap length either syncs or ends the frame
  task automatic m_low(input int len);
    int prev;
    prev = m_run;
    m_run += len;
    if (prev < M_GAP && m_run >= M_GAP) begin
      if (!m_sync) begin
        m_sync = 1;
      end else if (m_inframe) begin
        m_push(1, 24'(m_pix), 8'd0);
        if (m_bits != 0) m_push(2, 24'd3, 8'd0);
        m_inframe = 0; m_bits = 0; m_pix = 0;
      end
    end
  endtask

  task automatic hi(input int w);
    m_high(w);
    din = 1'b1;
    repeat (w) @(negedge clk);
  endtask

  task automatic lo(input int len);
    m_low(len);
    din = 1'b0;
    repeat (len) @(negedge clk);
  endtask

  // Top n bits of w, MSB first; tl==0 means low fills the rest of TBIT
  task automatic send_bits(input logic [23:0] w, input int n, input int t0, input int t1,
                           input int tl);
    int h;
    for (int i = 23; i > 23 - n; i--) begin
      h = w[i] ? t1 : t0;
      hi(h);
      lo((tl == 0) ? (TBIT - h) : tl);
    end
  endtask

  task automatic check_events(input string nm);
    int ne, na;
    ne = exp_q.size() - exp_rd;
    na = act_q.size() - act_rd;
    chk({nm, " event count"}, 32'(na), 32'(ne));
    for (int i = 0; i < ((ne < na) ? ne : na); i++) begin
      nchk++;
      if (act_q[act_rd+i].kind != exp_q[exp_rd+i].kind || act_q[act_rd+i].a !== exp_q[exp_rd+i].a ||
          act_q[act_rd+i].b !== exp_q[exp_rd+i].b) begin
        nfail++;
        $display("FAIL %s ev%0d: got kind=%0d a=%h b=%0d, want kind=%0d a=%h b=%0d", nm, i,
                 act_q[act_rd+i].kind, act_q[act_rd+i].a, act_q[act_rd+i].b,
                 exp_q[exp_rd+i].kind, exp_q[exp_rd+i].a, exp_q[exp_rd+i].b);
      end
    end
    exp_rd = exp_q.size();
    act_rd = act_q.size();
    chk({nm, " valid/frame_done overlap"}, 32'(n_coinc), 32'd0);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    chk({nm, " pix_data"},     32'(pix_data), 32'd0);
    chk({nm, " pix_valid"},    32'(pix_valid), 32'd0);
    chk({nm, " pix_index"},    32'(pix_index), 32'd0);
    chk({nm, " frame_done"},   32'(frame_done), 32'd0);
    chk({nm, " frame_pixels"}, 32'(frame_pixels), 32'd0);
    chk({nm, " err"},          32'(err), 32'd0);
    chk({nm, " err_code"},     32'(err_code), 32'd0);
    chk({nm, " busy"},         32'(busy), 32'd0);
    rst = 1'b1;
    m_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    logic [23:0] d;
    int          npx, r, h;

    tbl[0] = '{24'hA5C30F, 11, 12, 5, 24'hA5C30F};  // just below / at the '1' threshold
    tbl[1] = '{24'h300000, T0H, T1H, 0, 24'h300000};
    tbl[2] = '{24'hFFFFFF, 3, 39, 1, 24'hFFFFFF};   // longest legal high
    tbl[3] = '{24'h000000, 3, 39, 1, 24'h000000};   // shortest legal high
    tbl[4] = '{24'h5A3CF0, 11, 12, 2, 24'h5A3CF0};

    m_reset();
    do_reset("reset");

    // Decode table
    for (int i = 0; i < 5; i++) begin
      lo(1100);
      send_bits(tbl[i].word, 24, tbl[i].t0, tbl[i].t1, tbl[i].tl);
      lo(1100);
      chk($sformatf("table%0d pix_data", i), 32'(pix_data), 32'(tbl[i].exp_data));
      chk($sformatf("table%0d frame_pixels", i), 32'(frame_pixels), 32'd1);
      check_events($sformatf("table%0d", i));
    end

    // Loopback-style frame of 18 identical pixels at nominal timing
    lo(1100);
    chk("loop idle busy", 32'(busy), 32'd0);
    for (int p = 0; p < 18; p++) send_bits(24'h300000, 24, T0H, T1H, 0);
    lo(1100);
    chk("loop last index", 32'(pix_index), 32'd17);
    chk("loop frame_pixels", 32'(frame_pixels), 32'd18);
    chk("loop err_code", 32'(err_code), 32'd0);
    check_events("loopback");

    // Startup with line high: 1023 low is not enough, 1024 is
    do_reset("startup reset");
    hi(30);
    lo(1023);
    hi(T1H);
    lo(1024);
    send_bits(24'hC3A501, 24, T0H, T1H, 0);
    lo(1100);
    check_events("startup");

    // Glitch mid-pixel, garbage ignored until a full gap
    lo(1100);
    send_bits(24'hFFFFFF, 10, T0H, T1H, 0);
    hi(2);
    lo(10);
    send_bits(24'h123456, 24, T0H, T1H, 0);
    lo(1100);
    send_bits(24'h5A5A5A, 24, T0H, T1H, 0);
    lo(1100);
    chk("glitch err_code held", 32'(err_code), 32'd1);
    check_events("glitch");

    // Stuck high, then 13-bit partial frame with a 1023-cycle low inside it
    lo(1100);
    send_bits(24'hF00000, 5, T0H, T1H, 0);
    chk("stuck busy", 32'(busy), 32'd1);
    hi(40);
    lo(1100);
    send_bits(24'hABCDEF, 12, T0H, T1H, 1);
    lo(1022);
    hi(12);
    lo(1100);
    chk("partial frame_pixels", 32'(frame_pixels), 32'd0);
    chk("partial err_code", 32'(err_code), 32'd3);
    check_events("stuck/partial");

    // Reset during bit 10 of pixel 3
    lo(1100);
    for (int p = 0; p < 3; p++) send_bits(24'h010203 + 24'(p), 24, T0H, T1H, 0);
    send_bits(24'hFFFFFF, 9, T0H, T1H, 0);
    din = 1'b1;
    repeat (5) @(negedge clk);
    check_events("pre-reset");
    do_reset("midframe reset");
    lo(1100);
    send_bits(24'h0F0F0F, 24, T0H, T1H, 0);
    send_bits(24'hF0F0F0, 24, T0H, T1H, 0);
    lo(1100);
    check_events("post-reset");

    // Random frames with occasional glitches, stuck highs and near-gap lows
    for (int it = 0; it < 10; it++) begin
      lo(1100);
      npx = $urandom_range(1, 3);
      for (int p = 0; p < npx; p++) begin
        d = 24'($urandom);
        for (int i = 23; i >= 0; i--) begin
          r = $urandom_range(0, 199);
          if (r == 0)      h = $urandom_range(1, 2);
          else if (r == 1) h = $urandom_range(40, 48);
          else             h = d[i] ? $urandom_range(12, 39) : $urandom_range(3, 11);
          hi(h);
          lo($urandom_range(1, 8));
        end
        if ($urandom_range(0, 3) == 0) lo($urandom_range(1000, 1050));
      end
      lo(1100);
      check_events($sformatf("random%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
